// File: rtl/traffic_lamp_driver.sv
// Lamp driver for the intersection sequencer: phase decode, walker blink and countdown.
// Define TRAFFIC_CONFLICT_MON_EN to build in the conflict monitor and sticky FAULT state.
module traffic_lamp_driver #(
    parameter int WALK_TICKS   = 20,
    parameter int BLINK_HALF   = 4,
    parameter int FAULT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tick,
    input  logic [2:0] i_h_car,
    input  logic [2:0] i_v_car,
    input  logic [2:0] i_h_walker,
    input  logic [2:0] i_v_walker,
    output logic [3:0] o_h_car_lamp,
    output logic [3:0] o_v_car_lamp,
    output logic [1:0] o_h_walker_lamp,
    output logic [1:0] o_v_walker_lamp,
    output logic [4:0] o_h_walk_cnt,
    output logic [4:0] o_v_walk_cnt,
    output logic       o_fault
);
    localparam logic [2:0] C_RED   = 3'd0;
    localparam logic [2:0] C_GREEN = 3'd1;
    localparam logic [2:0] C_YEL   = 3'd2;
    localparam logic [2:0] C_LEFT  = 3'd3;
    localparam logic [2:0] C_TWINK = 3'd4;
    localparam int         BW      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [4:0] WALK_LD = 5'(WALK_TICKS);

    typedef enum logic {NORMAL, FAULT} state_t;

    function automatic logic [3:0] car_dec(input logic [2:0] c);
        logic [3:0] l;
        l = 4'b1000;
        unique case (1'b1)
            c == C_YEL:   l = 4'b0100;
            c == C_GREEN: l = 4'b0010;
            c == C_LEFT:  l = 4'b0001;
            default:      l = 4'b1000;
        endcase
        return l;
    endfunction

    function automatic logic [1:0] walk_dec(input logic [2:0] w, input logic ph);
        logic [1:0] l;
        l = 2'b10;
        unique case (1'b1)
            w == C_GREEN: l = 2'b01;
            w == C_TWINK: l = {1'b0, ph};
            default:      l = 2'b10;
        endcase
        return l;
    endfunction

    function automatic logic walk_act(input logic [2:0] w);
        return (w == C_GREEN) || (w == C_TWINK);
    endfunction

    function automatic logic [4:0] walk_nx(input logic act, input logic act_q,
                                           input logic tick, input logic [4:0] cnt);
        logic [4:0] n;
        n = 5'd0;
        if (act && !act_q)
            n = WALK_LD;
        else if (act && tick && cnt != 5'd0)
            n = cnt - 5'd1;
        else if (act)
            n = cnt;
        return n;
    endfunction

    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    logic          h_act_q, v_act_q;
    state_t        state_nx;

`ifdef TRAFFIC_CONFLICT_MON_EN
    localparam int CW = $clog2(FAULT_CYCLES + 1);

    function automatic logic car_ok(input logic [2:0] c);
        return c <= C_LEFT;
    endfunction

    function automatic logic walker_ok(input logic [2:0] w);
        return (w == C_RED) || (w == C_GREEN) || (w == C_TWINK);
    endfunction

    state_t        state;
    logic [CW-1:0] conf_cnt, conf_cnt_nx;
    logic          conflict;

    always_comb begin
        conflict = ((i_h_car != C_RED) && (i_v_car != C_RED))
                || ((i_h_car != C_RED) && (i_h_walker != C_RED))
                || ((i_v_car != C_RED) && (i_v_walker != C_RED))
                || !car_ok(i_h_car) || !car_ok(i_v_car)
                || !walker_ok(i_h_walker) || !walker_ok(i_v_walker);
    end

    // A clean cycle always wins over reaching the threshold
    always_comb begin
        conf_cnt_nx = '0;
        state_nx    = state;
        if (conflict) begin
            if (conf_cnt == CW'(FAULT_CYCLES))
                conf_cnt_nx = conf_cnt;
            else
                conf_cnt_nx = conf_cnt + 1'b1;
            if (conf_cnt_nx == CW'(FAULT_CYCLES))
                state_nx = FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= NORMAL;
            conf_cnt <= '0;
        end else begin
            state    <= state_nx;
            conf_cnt <= conf_cnt_nx;
        end
    end
`else
    assign state_nx = NORMAL;
`endif

    logic [3:0] h_car_nx, v_car_nx;
    logic [1:0] h_wlk_nx, v_wlk_nx;
    logic [4:0] h_cnt_nx, v_cnt_nx;

    always_comb begin
        h_car_nx = car_dec(i_h_car);
        v_car_nx = car_dec(i_v_car);
        h_wlk_nx = walk_dec(i_h_walker, blink_ph);
        v_wlk_nx = walk_dec(i_v_walker, blink_ph);
        h_cnt_nx = walk_nx(walk_act(i_h_walker), h_act_q, i_tick, o_h_walk_cnt);
        v_cnt_nx = walk_nx(walk_act(i_v_walker), v_act_q, i_tick, o_v_walk_cnt);
        if (state_nx == FAULT) begin
            h_car_nx = {1'b0, blink_ph, 2'b00};
            v_car_nx = {1'b0, blink_ph, 2'b00};
            h_wlk_nx = 2'b10;
            v_wlk_nx = 2'b10;
            h_cnt_nx = 5'd0;
            v_cnt_nx = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt       <= '0;
            blink_ph        <= 1'b1;
            h_act_q         <= 1'b0;
            v_act_q         <= 1'b0;
            o_h_car_lamp    <= 4'b1000;
            o_v_car_lamp    <= 4'b1000;
            o_h_walker_lamp <= 2'b10;
            o_v_walker_lamp <= 2'b10;
            o_h_walk_cnt    <= 5'd0;
            o_v_walk_cnt    <= 5'd0;
            o_fault         <= 1'b0;
        end else begin
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            h_act_q         <= walk_act(i_h_walker);
            v_act_q         <= walk_act(i_v_walker);
            o_h_car_lamp    <= h_car_nx;
            o_v_car_lamp    <= v_car_nx;
            o_h_walker_lamp <= h_wlk_nx;
            o_v_walker_lamp <= v_wlk_nx;
            o_h_walk_cnt    <= h_cnt_nx;
            o_v_walk_cnt    <= v_cnt_nx;
            o_fault         <= (state_nx == FAULT);
        end
    end
endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Directed bench for traffic_lamp_driver; conflict checks follow TRAFFIC_CONFLICT_MON_EN.
module tb_traffic_lamp_driver;
    logic       clk = 1'b0;
    logic       reset;
    logic       i_tick;
    logic [2:0] i_h_car, i_v_car, i_h_walker, i_v_walker;
    logic [3:0] o_h_car_lamp, o_v_car_lamp;
    logic [1:0] o_h_walker_lamp, o_v_walker_lamp;
    logic [4:0] o_h_walk_cnt, o_v_walk_cnt;
    logic       o_fault;

    int n_checks = 0;
    int n_errors = 0;
    int edges = 0;

    logic [2:0] car_codes [4];
    logic [3:0] car_lamps [4];

    always #5 clk = ~clk;

    traffic_lamp_driver dut (
        .clk(clk), .reset(reset), .i_tick(i_tick),
        .i_h_car(i_h_car), .i_v_car(i_v_car),
        .i_h_walker(i_h_walker), .i_v_walker(i_v_walker),
        .o_h_car_lamp(o_h_car_lamp), .o_v_car_lamp(o_v_car_lamp),
        .o_h_walker_lamp(o_h_walker_lamp), .o_v_walker_lamp(o_v_walker_lamp),
        .o_h_walk_cnt(o_h_walk_cnt), .o_v_walk_cnt(o_v_walk_cnt),
        .o_fault(o_fault)
    );

    // Non-reset edges since the last reset edge
    always @(posedge clk) begin
        if (reset) edges = 0;
        else       edges = edges + 1;
    end

    // Blink phase sampled at the most recent edge: on for 4 edges, off for 4
    function automatic logic ph();
        return (((edges - 1) / 4) % 2) == 0;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_h_car = 3'd0; i_v_car = 3'd0;
        i_h_walker = 3'd0; i_v_walker = 3'd0;
        i_tick = 1'b0;
    endtask

    initial begin
        car_codes = '{3'd1, 3'd2, 3'd3, 3'd0};
        car_lamps = '{4'b0010, 4'b0100, 4'b0001, 4'b1000};

        reset = 1'b1;
        i_h_car = 3'd1; i_v_car = 3'd3;
        i_h_walker = 3'd4; i_v_walker = 3'd5;
        i_tick = 1'b1;
        step(3);
        check("rst_h_car", 8'(o_h_car_lamp), 8'b1000);
        check("rst_v_car", 8'(o_v_car_lamp), 8'b1000);
        check("rst_h_wlk", 8'(o_h_walker_lamp), 8'b10);
        check("rst_v_wlk", 8'(o_v_walker_lamp), 8'b10);
        check("rst_h_cnt", 8'(o_h_walk_cnt), 8'd0);
        check("rst_v_cnt", 8'(o_v_walk_cnt), 8'd0);
        check("rst_fault", 8'(o_fault), 8'd0);
        idle();
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            i_h_car = car_codes[i];
            step();
            check("car_dec", 8'(o_h_car_lamp), 8'(car_lamps[i]));
            check("car_dec_v", 8'(o_v_car_lamp), 8'b1000);
        end

        i_h_car = 3'd1; i_v_car = 3'd1;
        step();
        check("glitch_fault", 8'(o_fault), 8'd0);
        check("glitch_h", 8'(o_h_car_lamp), 8'b0010);
        check("glitch_v", 8'(o_v_car_lamp), 8'b0010);
        idle();
        step();
        check("glitch_fault2", 8'(o_fault), 8'd0);
        check("glitch_h2", 8'(o_h_car_lamp), 8'b1000);

        for (int p = 0; p < 20; p++) begin
            i_v_walker = (p < 14) ? 3'd1 : 3'd4;
            i_tick = 1'b1;
            step();
            i_tick = 1'b0;
            check("walk_cnt", 8'(o_v_walk_cnt), 8'(20 - p));
            for (int c = 0; c < 8; c++) begin
                if (c > 0) step();
                if (p < 14) begin
                    if (c == 0) check("walk_green", 8'(o_v_walker_lamp), 8'b01);
                end else begin
                    check("walk_twinkle", 8'(o_v_walker_lamp), {7'd0, ph()});
                end
            end
            check("walk_hold", 8'(o_v_walk_cnt), 8'(20 - p));
        end
        i_v_walker = 3'd0;
        step();
        check("walk_end_cnt", 8'(o_v_walk_cnt), 8'd0);
        check("walk_end_lamp", 8'(o_v_walker_lamp), 8'b10);

        i_h_walker = 3'd1;
        step();
        check("sat_load", 8'(o_h_walk_cnt), 8'd20);
        i_tick = 1'b1;
        step(22);
        check("sat_zero", 8'(o_h_walk_cnt), 8'd0);
        idle();
        step();

        i_h_walker = 3'd1;
        step();
        i_tick = 1'b1;
        step();
        check("mid_dec", 8'(o_h_walk_cnt), 8'd19);
        reset = 1'b1;
        step();
        check("mid_rst_cnt", 8'(o_h_walk_cnt), 8'd0);
        check("mid_rst_lamp", 8'(o_h_walker_lamp), 8'b10);
        reset = 1'b0;
        step();
        check("mid_reload", 8'(o_h_walk_cnt), 8'd20);
        idle();
        step();

`ifdef TRAFFIC_CONFLICT_MON_EN
        i_v_walker = 3'd1; i_v_car = 3'd3;
        step();
        check("conf_1st", 8'(o_fault), 8'd0);
        step();
        check("conf_fault", 8'(o_fault), 8'd1);
        check("conf_v_wlk", 8'(o_v_walker_lamp), 8'b10);
        check("conf_v_cnt", 8'(o_v_walk_cnt), 8'd0);
        check("conf_h_car", 8'(o_h_car_lamp), {5'd0, ph(), 2'b00});
        idle();
        for (int c = 0; c < 10; c++) begin
            step();
            check("fault_blink", 8'(o_v_car_lamp), {5'd0, ph(), 2'b00});
            check("fault_sticky", 8'(o_fault), 8'd1);
        end
        reset = 1'b1;
        step();
        check("fault_rst", 8'(o_fault), 8'd0);
        check("fault_rst_car", 8'(o_v_car_lamp), 8'b1000);
        reset = 1'b0;

        i_h_walker = 3'd5;
        step();
        check("inv_1st", 8'(o_fault), 8'd0);
        step();
        check("inv_fault", 8'(o_fault), 8'd1);
        check("inv_wlk", 8'(o_h_walker_lamp), 8'b10);
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
`else
        i_v_walker = 3'd1; i_v_car = 3'd3;
        step(2);
        check("nomon_fault", 8'(o_fault), 8'd0);
        check("nomon_v_car", 8'(o_v_car_lamp), 8'b0001);
        check("nomon_v_wlk", 8'(o_v_walker_lamp), 8'b01);
        idle();
        i_h_walker = 3'd5;
        step(2);
        check("inv_wlk", 8'(o_h_walker_lamp), 8'b10);
        check("inv_fault", 8'(o_fault), 8'd0);
        idle();
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
